prbs_seq_ctrl: RTL

//  Sequencer for the PRBS generator datapath: seeds the LFSR, runs it for a programmed

---
 rtl/prbs_seq_ctrl_pkg.sv | 21 ++
 rtl/prbs_seq_ctrl_lfsr.sv | 37 +++
 rtl/prbs_seq_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/prbs_seq_ctrl_pkg.sv
// prbs_seq_ctrl_pkg
//   Shared definitions for the PRBS sequencer slice: FSM state encoding
//   and the default maximal-length tap masks for the supported LFSR widths.
//   No ports (package).
package prbs_seq_ctrl_pkg;

  // Encodings are fixed so generator and checker blocks decode state_dbg alike.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Fibonacci feedback masks; bit k-1 set for each x^k term of the polynomial.
  localparam logic [2:0]  TAPS_W3  = 3'b110;                           // x^3+x^2+1
  localparam logic [6:0]  TAPS_W7  = 7'b110_0000;                      // x^7+x^6+1
  localparam logic [14:0] TAPS_W15 = 15'b110_0000_0000_0000;           // x^15+x^14+1
  localparam logic [30:0] TAPS_W31 = 31'b100_1000_0000_0000_0000_0000_0000_0000; // x^31+x^28+1

endpackage

// File: rtl/prbs_seq_ctrl_lfsr.sv
// prbs_lfsr
//   Fibonacci LFSR register. Shifts left, feedback enters at bit 0:
//   state <= {state[WIDTH-2:0], ^(state & TAPS)}.
// Ports
//   clk       rising-edge clock
//   R         synchronous active-high reset (state -> all ones)
//   load      load seed this cycle (has priority over shift_en)
//   seed      value loaded when load=1
//   shift_en  advance one step
//   state     current register contents
module prbs_lfsr #(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = 3'b110
) (
  input  logic             clk,
  input  logic             R,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             shift_en,
  output logic [WIDTH-1:0] state
);

  logic fb;

  assign fb = ^(state & TAPS);

  always_ff @(posedge clk) begin
    if (R) begin
      state <= '1;
    end else if (load) begin
      state <= seed;
    end else if (shift_en) begin
      state <= {state[WIDTH-2:0], fb};
    end
  end

endmodule

// File: rtl/prbs_seq_ctrl.sv
// prbs_seq_ctrl
//   Sequences a PRBS burst: captures seed/len on start, loads the LFSR,
//   streams len bits to a consumer under a valid/ready stall handshake,
//   then pulses done. An all-zero seed is replaced by all ones so the
//   LFSR cannot lock up. abort returns to IDLE from LOAD or RUN.
//
//   Optional feature macro: PRBS_ERR_INJECT_EN (single-bit error inject).
//
// Ports
//   clk        rising-edge clock
//   R          synchronous active-high reset
//   start      begin burst (sampled in IDLE only)
//   abort      terminate burst (sampled in LOAD/RUN)
//   seed       initial LFSR state, captured with start
//   len        number of bits to emit, captured with start
//   inject     error request (only used with PRBS_ERR_INJECT_EN)
//   ready_in   consumer accepts out_bit this cycle
//   out_bit    PRBS bit (LFSR MSB while valid, else 0)
//   out_valid  out_bit is valid (RUN)
//   busy       high in LOAD and RUN
//   done       one-cycle pulse on normal completion
//   lfsr_q     current LFSR state
//   state_dbg  current FSM state (prbs_seq_ctrl_pkg::state_t encoding)
//
// Handshake: a bit is transferred ("accept") in every cycle where
// out_valid && ready_in. out_valid never depends on ready_in; while
// ready_in=0 the bit, LFSR and counter hold. abort in the same cycle as
// ready_in wins: the bit is not transferred.
module prbs_seq_ctrl
  import prbs_seq_ctrl_pkg::*;
#(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = 3'b110,
  parameter int               LEN_W = 16
) (
  input  logic             clk,
  input  logic             R,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [LEN_W-1:0] len,
  input  logic             inject,
  input  logic             ready_in,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lfsr_q,
  output logic [1:0]       state_dbg
);

  state_t           state;
  logic [WIDTH-1:0] seed_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             accept;
  logic             lfsr_load;
  logic             lfsr_shift;
  logic             err_flip;

  assign accept     = (state == S_RUN) && ready_in && !abort;
  assign lfsr_load  = (state == S_LOAD);
  assign lfsr_shift = accept;

  prbs_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clk      (clk),
    .R        (R),
    .load     (lfsr_load),
    .seed     (seed_q),
    .shift_en (lfsr_shift),
    .state    (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (R) begin
      state  <= S_IDLE;
      seed_q <= '1;
      len_q  <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // All-zero is the LFSR's stuck state; substitute all ones.
            seed_q <= (seed == '0) ? '1 : seed;
            len_q  <= len;
            state  <= (len == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          cnt <= '0;
          if (abort) state <= S_IDLE;
          else       state <= S_RUN;
        end
        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (ready_in) begin
            cnt <= cnt + LEN_W'(1);
            // This accept is the last bit of the burst.
            if (cnt == len_q - LEN_W'(1)) state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  // inj_pend inverts the bit currently offered. An accept retires it; an
  // inject seen on that same accept arms the flip for the following bit.
  logic inj_pend;

  always_ff @(posedge clk) begin
    if (R) begin
      inj_pend <= 1'b0;
    end else if (state != S_RUN || abort) begin
      inj_pend <= 1'b0;
    end else if (accept) begin
      inj_pend <= inject;
    end else if (inject) begin
      inj_pend <= 1'b1;
    end
  end

  assign err_flip = inj_pend;
`else
  logic unused_inject;
  assign unused_inject = inject;
  assign err_flip      = 1'b0;
`endif

  assign out_valid = (state == S_RUN);
  assign busy      = (state == S_LOAD) || (state == S_RUN);
  assign done      = (state == S_DONE);
  assign out_bit   = out_valid & (lfsr_q[WIDTH-1] ^ err_flip);
  assign state_dbg = state;

endmodule
